writeback_arbiter: RTL and testbench

- Shares the single X__W writeback port among p_num_units execute units (ALU, multiplier, control flow unit, ...).
- Each unit presents a valid/ready X__W message; the block grants one per cycle by round-robin and registers it into a one-entry output stage toward W.
- Sits between the execute units and the writeback stage; provides fair, starvation-free, full-throughput access.

---
 rtl/writeback_arbiter_pkg.sv | 17 +
 rtl/writeback_arbiter_rr_arbiter.sv | 47 ++++
 rtl/writeback_arbiter.sv | 95 +++++++++
 tb/tb_writeback_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared micro-architecture definitions for the X->W writeback path:
// message field widths, output-stage state encoding and round-robin helper.
package writeback_arbiter_pkg;

  localparam int unsigned PcBits      = 32;
  localparam int unsigned RegAddrBits = 5;
  localparam int unsigned DataBits    = 32;

  // One-entry output stage occupancy.
  typedef enum logic {StEmpty, StFull} out_state_e;

  // Index following `idx` in a ring of `num` requesters.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from a rotating priority
// pointer; the pointer moves past the winner whenever a grant is issued.
module writeback_arbiter_rr_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic              en,
  output logic [NumReq-1:0] grant
);

  localparam int unsigned PtrBits = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrBits-1:0] ptr_q;
  logic [PtrBits-1:0] idx;
  logic [PtrBits-1:0] grant_idx;
  logic               found;

  // First requester at or after the pointer, wrapping around the ring.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = PtrBits'((32'(ptr_q) + k) % NumReq);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

  // Priority pointer advances past the winner only on an actual grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (en && found) begin
      ptr_q <= PtrBits'(rr_next(32'(grant_idx), NumReq));
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: shares the single X->W port among execute units.
// Grants one request per cycle by round-robin into a one-entry output
// register; a full register can be refilled in the same cycle it drains.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned p_num_units    = 3,
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [p_num_units-1:0]                       req_val,
  output logic [p_num_units-1:0]                       req_rdy,
  input  logic [p_num_units-1:0][PcBits-1:0]           req_pc,
  input  logic [p_num_units-1:0][p_seq_num_bits-1:0]   req_seq_num,
  input  logic [p_num_units-1:0][RegAddrBits-1:0]      req_waddr,
  input  logic [p_num_units-1:0][DataBits-1:0]         req_wdata,
  input  logic [p_num_units-1:0]                       req_wen,
  output logic                                         W_val,
  input  logic                                         W_rdy,
  output logic [PcBits-1:0]                            W_pc,
  output logic [p_seq_num_bits-1:0]                    W_seq_num,
  output logic [RegAddrBits-1:0]                       W_waddr,
  output logic [DataBits-1:0]                          W_wdata,
  output logic                                         W_wen
);

  // Seq-num width is a parameter, so the message type lives here rather
  // than in the package.
  typedef struct packed {
    logic [PcBits-1:0]         pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [RegAddrBits-1:0]    waddr;
    logic [DataBits-1:0]       wdata;
    logic                      wen;
  } xw_msg_t;

  out_state_e             state_q;
  xw_msg_t                msg_q;
  xw_msg_t                sel_msg;
  logic                   can_accept;
  logic                   grant_any;
  logic [p_num_units-1:0] grant;

  assign can_accept = (state_q == StEmpty) || W_rdy;

  // Gating with rst keeps req_rdy low for the whole reset period.
  writeback_arbiter_rr_arbiter #(
    .NumReq (p_num_units)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .req   (req_val),
    .en    (can_accept & rst),
    .grant (grant)
  );

  assign req_rdy   = grant;
  assign grant_any = |grant;

  // Select the granted unit's message; grant is one-hot.
  always_comb begin
    sel_msg = '0;
    for (int unsigned i = 0; i < p_num_units; i++) begin
      if (grant[i]) begin
        sel_msg.pc      = req_pc[i];
        sel_msg.seq_num = req_seq_num[i];
        sel_msg.waddr   = req_waddr[i];
        sel_msg.wdata   = req_wdata[i];
        sel_msg.wen     = req_wen[i];
      end
    end
  end

  // Output stage: a grant always (re)fills; otherwise a dequeue empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      msg_q   <= '0;
    end else if (grant_any) begin
      state_q <= StFull;
      msg_q   <= sel_msg;
    end else if (state_q == StFull && W_rdy) begin
      state_q <= StEmpty;
    end
  end

  assign W_val     = (state_q == StFull);
  assign W_pc      = msg_q.pc;
  assign W_seq_num = msg_q.seq_num;
  assign W_waddr   = msg_q.waddr;
  assign W_wdata   = msg_q.wdata;
  assign W_wen     = msg_q.wen;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus a
// randomised stream checked against a behavioural model and per-unit queues.
module tb_writeback_arbiter;

  localparam int N  = 3;
  localparam int S  = 5;
  localparam int MW = 32 + S + 5 + 32 + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         req_val = '0;
  logic [N-1:0]         req_rdy;
  logic [N-1:0][31:0]   req_pc = '0;
  logic [N-1:0][S-1:0]  req_seq_num = '0;
  logic [N-1:0][4:0]    req_waddr = '0;
  logic [N-1:0][31:0]   req_wdata = '0;
  logic [N-1:0]         req_wen = '0;
  logic                 W_val;
  logic                 W_rdy = 1'b0;
  logic [31:0]          W_pc;
  logic [S-1:0]         W_seq_num;
  logic [4:0]           W_waddr;
  logic [31:0]          W_wdata;
  logic                 W_wen;

  writeback_arbiter #(
    .p_num_units    (N),
    .p_seq_num_bits (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_pc      (req_pc),
    .req_seq_num (req_seq_num),
    .req_waddr   (req_waddr),
    .req_wdata   (req_wdata),
    .req_wen     (req_wen),
    .W_val       (W_val),
    .W_rdy       (W_rdy),
    .W_pc        (W_pc),
    .W_seq_num   (W_seq_num),
    .W_waddr     (W_waddr),
    .W_wdata     (W_wdata),
    .W_wen       (W_wen)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: holding flag, held message, next-priority unit.
  bit             m_full = 1'b0;
  logic [MW-1:0]  m_msg  = '0;
  int             m_ptr  = 0;

  function automatic logic [MW-1:0] in_msg(int u);
    return {req_pc[u], req_seq_num[u], req_waddr[u], req_wdata[u], req_wen[u]};
  endfunction

  function automatic logic [MW-1:0] out_msg();
    return {W_pc, W_seq_num, W_waddr, W_wdata, W_wen};
  endfunction

  // Unit that should be accepted this cycle, or -1.
  function automatic int model_pick();
    if (m_full && !W_rdy) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_val[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int u);
    logic [N-1:0] r;
    r = '0;
    if (u >= 0) r[u] = 1'b1;
    return r;
  endfunction

  task automatic set_msg(int u, logic [31:0] pc, logic [S-1:0] seq, logic [4:0] wa,
                         logic [31:0] wd, logic we);
    req_pc[u]      = pc;
    req_seq_num[u] = seq;
    req_waddr[u]   = wa;
    req_wdata[u]   = wd;
    req_wen[u]     = we;
  endtask

  // Advance one clock and the model with it; returns 1 ns after the edge.
  task automatic cycle();
    int            g;
    logic [MW-1:0] nm;
    g  = model_pick();
    nm = (g >= 0) ? in_msg(g) : '0;
    @(posedge clk);
    if (g >= 0) begin
      m_full = 1'b1;
      m_msg  = nm;
      m_ptr  = (g + 1) % N;
    end else if (m_full && W_rdy) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    req_val = '0;
    W_rdy   = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    m_full = 1'b0;
    m_ptr  = 0;
  endtask

  task automatic std_msgs();
    for (int u = 0; u < N; u++) set_msg(u, 32'h1000 + u, S'(u), 5'(u + 1), 32'ha0 + u, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_val = '1; W_rdy = 1'b1;
    #3;
    n_cmp++;
    if (req_rdy !== '0) begin n_bad++; $display("FAIL reset_req_rdy got %b want 000", req_rdy); end
    n_cmp++;
    if (W_val !== 1'b0) begin n_bad++; $display("FAIL reset_w_val got %b want 0", W_val); end
    n_cmp++;
    if (out_msg() !== '0) begin n_bad++; $display("FAIL reset_w_msg got %h want 0", out_msg()); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_msg(0, 32'h200, 5'd3, 5'd5, 32'hdeadbeef, 1'b1);
    req_val = 3'b001; W_rdy = 1'b1;
    #1;
    n_cmp++;
    if (req_rdy !== 3'b001) begin n_bad++; $display("FAIL single_rdy got %b want 001", req_rdy); end
    cycle();
    req_val = '0;
    n_cmp++;
    if (W_val !== 1'b1 || out_msg() !== {32'h200, 5'd3, 5'd5, 32'hdeadbeef, 1'b1}) begin
      n_bad++; $display("FAIL single_msg got val=%b %h", W_val, out_msg());
    end
    // Pointer now at 1: with units 0 and 1 requesting, unit 1 wins.
    req_val = 3'b011;
    #1;
    n_cmp++;
    if (req_rdy !== 3'b010) begin n_bad++; $display("FAIL single_ptr got %b want 010", req_rdy); end
    cycle();
    req_val = '0;
    cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    std_msgs();
    req_val = '1; W_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if (req_rdy !== onehot(k % N)) begin
        n_bad++; $display("FAIL b2b_rdy[%0d] got %b want %b", k, req_rdy, onehot(k % N));
      end
      cycle();
      n_cmp++;
      if (W_val !== 1'b1 || W_pc !== 32'h1000 + 32'(k % N)) begin
        n_bad++; $display("FAIL b2b_out[%0d] got val=%b pc=%h want pc=%h", k, W_val, W_pc,
                          32'h1000 + 32'(k % N));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    std_msgs();
    req_val = '1; W_rdy = 1'b0;
    cycle();
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (req_rdy !== '0) begin n_bad++; $display("FAIL stall_rdy[%0d] got %b want 000", k, req_rdy); end
      cycle();
      n_cmp++;
      if (W_val !== 1'b1 || W_pc !== 32'h1000) begin
        n_bad++; $display("FAIL stall_hold[%0d] got val=%b pc=%h want pc=00001000", k, W_val, W_pc);
      end
    end
    W_rdy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_cmp++;
      if (req_rdy !== onehot(k % N)) begin
        n_bad++; $display("FAIL stall_resume_rdy[%0d] got %b want %b", k, req_rdy, onehot(k % N));
      end
      cycle();
      n_cmp++;
      if (W_pc !== 32'h1000 + 32'(k % N)) begin
        n_bad++; $display("FAIL stall_resume_pc[%0d] got %h want %h", k, W_pc, 32'h1000 + 32'(k % N));
      end
    end
  endtask

  task automatic test_skip();
    do_reset();
    std_msgs();
    W_rdy = 1'b1; req_val = 3'b001;
    cycle();
    req_val = 3'b101;
    for (int k = 0; k < 3; k++) begin
      int e;
      e = (k % 2 == 0) ? 2 : 0;
      #1;
      n_cmp++;
      if (req_rdy !== onehot(e)) begin
        n_bad++; $display("FAIL skip_rdy[%0d] got %b want %b", k, req_rdy, onehot(e));
      end
      cycle();
      n_cmp++;
      if (W_pc !== 32'h1000 + 32'(e)) begin
        n_bad++; $display("FAIL skip_pc[%0d] got %h want %h", k, W_pc, 32'h1000 + 32'(e));
      end
    end
  endtask

  task automatic test_wen0();
    do_reset();
    set_msg(1, 32'h300, 5'd9, 5'd7, 32'h12345678, 1'b0);
    req_val = 3'b010; W_rdy = 1'b1;
    cycle();
    req_val = '0;
    n_cmp++;
    if (W_val !== 1'b1 || W_wen !== 1'b0 || W_waddr !== 5'd7 || W_pc !== 32'h300) begin
      n_bad++; $display("FAIL wen0 got val=%b wen=%b waddr=%0d pc=%h want 1 0 7 300",
                        W_val, W_wen, W_waddr, W_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    std_msgs();
    req_val = '1; W_rdy = 1'b1;
    cycle();
    cycle();
    #2;
    rst = 1'b0;
    #1;
    m_full = 1'b0; m_ptr = 0;
    n_cmp++;
    if (W_val !== 1'b0) begin n_bad++; $display("FAIL midrst_w_val got %b want 0", W_val); end
    n_cmp++;
    if (req_rdy !== '0) begin n_bad++; $display("FAIL midrst_rdy got %b want 000", req_rdy); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_val = 3'b110;
    #1;
    n_cmp++;
    if (req_rdy !== 3'b010) begin n_bad++; $display("FAIL midrst_ptr got %b want 010", req_rdy); end
    cycle();
    n_cmp++;
    if (W_val !== 1'b1 || W_pc !== 32'h1001) begin
      n_bad++; $display("FAIL midrst_out got val=%b pc=%h want pc=00001001", W_val, W_pc);
    end
  endtask

  task automatic test_random();
    logic [MW-1:0] exp_q[N][$];
    int            dly[N];
    int            cnt;
    int            g;
    int            u;
    logic [MW-1:0] front;
    do_reset();
    cnt = 0;
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_val[i] && cyc < 560) begin
          if (dly[i] == 0) begin
            set_msg(i, {cnt[28:0], 3'(i)}, S'($urandom), 5'($urandom), $urandom, 1'($urandom));
            req_val[i] = 1'b1;
            cnt++;
          end else begin
            dly[i]--;
          end
        end
      end
      W_rdy = (cyc >= 560) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      g = model_pick();
      n_cmp++;
      if (req_rdy !== onehot(g)) begin
        n_bad++; $display("FAIL rand_rdy[%0d] got %b want %b", cyc, req_rdy, onehot(g));
      end
      if (W_val === 1'b1 && W_rdy) begin
        u = int'(W_pc[2:0]);
        n_cmp++;
        if (u >= N || exp_q[u].size() == 0) begin
          n_bad++; $display("FAIL rand_unexpected[%0d] got %h want nothing pending", cyc, out_msg());
        end else begin
          front = exp_q[u].pop_front();
          if (out_msg() !== front) begin
            n_bad++; $display("FAIL rand_order[%0d] got %h want %h", cyc, out_msg(), front);
          end
        end
      end
      if (g >= 0) exp_q[g].push_back(in_msg(g));
      cycle();
      if (g >= 0) begin
        req_val[g] = 1'b0;
        dly[g]     = $urandom_range(0, 3);
      end
      n_cmp++;
      if (W_val !== m_full || (m_full && out_msg() !== m_msg)) begin
        n_bad++; $display("FAIL rand_out[%0d] got val=%b %h want val=%b %h", cyc, W_val, out_msg(),
                          m_full, m_msg);
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (exp_q[i].size() != 0) begin
        n_bad++; $display("FAIL rand_lost unit %0d got %0d undelivered want 0", i, exp_q[i].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_skip();
    test_wen0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
